// File: rtl/apb_selfcheck_master_if.sv
// APB bus bundle between the self-check master and the subsystem slave port.
interface apb_selfcheck_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   paddr;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [DATA_W/8-1:0] pstrb;
   logic [DATA_W-1:0]   prdata;
   logic                pready;
   logic                pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_selfcheck_master.sv
// Autonomous APB master: writes a stepped pattern over a word window, reads it
// back and reports busy/done/pass, a saturating error count and a timeout flag.
module apb_selfcheck_master #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                NUM_WORDS    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
   parameter logic [31:0]       PATTERN_BASE = 32'hA5A5_0000,
   parameter logic [31:0]       PATTERN_STEP = 32'h0000_0011,
   parameter int                START_DELAY  = 4,
   parameter int                TIMEOUT      = 64,
   parameter bit                AUTO_START   = 1'b1,
   parameter int                ERR_W        = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   apb_selfcheck_master_if.master apb,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout,
   output logic [ERR_W-1:0]       err_count
);
   localparam int BYTES = DATA_W / 8;
   localparam int IW    = $clog2(NUM_WORDS + 1);
   localparam int DCW   = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
   localparam int WCW   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_ACCESS, S_DONE} state_t;

   function automatic logic [DATA_W-1:0] pat_f(input logic [IW-1:0] i);
      return PATTERN_BASE[DATA_W-1:0] + PATTERN_STEP[DATA_W-1:0] * DATA_W'(i);
   endfunction

   function automatic logic [ADDR_W-1:0] addr_f(input logic [IW-1:0] i);
      return BASE_ADDR + ADDR_W'(i) * ADDR_W'(BYTES);
   endfunction

   state_t              state_q, state_d;
   logic                phase_q, phase_d;    // 0 = write pass, 1 = read pass
   logic [IW-1:0]       idx_q, idx_d;
   logic [DCW-1:0]      dcnt_q, dcnt_d;
   logic [WCW-1:0]      wcnt_q, wcnt_d;
   logic                auto_q, auto_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                tmo_q, tmo_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [ADDR_W-1:0]   paddr_q;
   logic                psel_q, penable_q, pwrite_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic [BYTES-1:0]    pstrb_q;
   logic                load, trig, bad;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      dcnt_d  = dcnt_q;
      wcnt_d  = wcnt_q;
      auto_d  = auto_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      load    = 1'b0;
      bad     = apb.pslverr || (phase_q && (apb.prdata != pat_f(idx_q)));
      // busy is still high for the first DONE cycle, so start there is ignored too
      trig    = !busy_q && ((state_q == S_IDLE && (start || auto_q)) ||
                            (state_q == S_DONE && start));

      case (state_q)
         S_WAIT: begin
            if (dcnt_q == DCW'(START_DELAY)) begin
               state_d = S_SETUP;
               load    = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            wcnt_d  = '0;
         end
         S_ACCESS: begin
            if (apb.pready) begin
               if (bad && err_q != '1) err_d = err_q + ERR_W'(1);
               if (idx_q != IW'(NUM_WORDS - 1)) begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_SETUP;
                  load    = 1'b1;
               end else if (!phase_q) begin
                  phase_d = 1'b1;
                  idx_d   = '0;
                  state_d = S_SETUP;
                  load    = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
               // abort: results are published on this same edge
               state_d = S_DONE;
               tmo_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pass_d = (err_q == '0) && !tmo_q;
         end
         default: ;
      endcase

      if (trig) begin
         state_d = S_WAIT;
         auto_d  = 1'b0;
         phase_d = 1'b0;
         idx_d   = '0;
         dcnt_d  = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         tmo_d   = 1'b0;
         err_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         phase_q   <= 1'b0;
         idx_q     <= '0;
         dcnt_q    <= '0;
         wcnt_q    <= '0;
         auto_q    <= AUTO_START;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         tmo_q     <= 1'b0;
         err_q     <= '0;
         paddr_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         dcnt_q    <= dcnt_d;
         wcnt_q    <= wcnt_d;
         auto_q    <= auto_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         psel_q    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
         penable_q <= (state_d == S_ACCESS);
         // address/data/strobe change only when a new SETUP begins
         if (load) begin
            paddr_q  <= addr_f(idx_d);
            pwrite_q <= !phase_d;
            pwdata_q <= phase_d ? '0 : pat_f(idx_d);
            pstrb_q  <= phase_d ? '0 : '1;
         end
      end
   end

   assign apb.paddr   = paddr_q;
   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.pstrb   = pstrb_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign timeout     = tmo_q;
   assign err_count   = err_q;
endmodule

// File: tb/tb_apb_selfcheck_master.sv
// Randomized bench: RAM slave with configurable waits/errors, reference model
// feeding transfer and result scoreboards, monitors comparing on DUT events.
module tb_apb_selfcheck_master;
  localparam int SD = 4;
  localparam int TO = 64;
  localparam int EW = 3;

  typedef struct { logic [31:0] addr; bit wr; logic [31:0] data; } txn_t;
  typedef struct { int err; bit pass; bit tmo; int cyc; } res_t;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic busy, done, pass, timeout;
  logic [EW-1:0] err_count;

  apb_selfcheck_master_if #(.ADDR_W(32), .DATA_W(32)) apb();

  apb_selfcheck_master #(
    .ADDR_W(32), .DATA_W(32), .NUM_WORDS(4), .BASE_ADDR(32'h1000),
    .PATTERN_BASE(32'hA5A5_0000), .PATTERN_STEP(32'h11), .START_DELAY(SD),
    .TIMEOUT(TO), .AUTO_START(1'b1), .ERR_W(EW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .apb(apb),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  txn_t tq[$];
  res_t rq[$];
  int   wq[$];
  bit [7:0] slv_mask = '0;
  int   stuck = -1;
  bit   hang = 1'b0;
  logic [31:0] mem [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // reference model: expected transfers and run result from the slave config
  task automatic arm(input bit [7:0] mask, input int stk, input int wfix, input bit hng);
    int lat, err, w, i;
    logic [31:0] p, d;
    txn_t t;
    res_t r;
    slv_mask = mask; stuck = stk; hang = hng;
    wq.delete();
    err = 0;
    lat = SD + 2;
    if (hng) lat = SD + 2 + TO;
    else for (int k = 0; k < 8; k++) begin
      i = k % 4;
      w = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
      wq.push_back(w);
      lat += 2 + w;
      p = 32'hA5A5_0000 + 32'h11 * i;
      t.addr = 32'h1000 + 4 * i; t.wr = (k < 4); t.data = p;
      tq.push_back(t);
      if (k < 4) err += int'(mask[k]);
      else begin
        d = (i == stk) ? 32'h0 : p;
        if (mask[k] || d != p) err++;
      end
    end
    r.err = (err > 7) ? 7 : err;
    r.tmo = hng;
    r.pass = (r.err == 0) && !hng;
    r.cyc = cyc + 1 + lat;
    rq.push_back(r);
  endtask

  task automatic go_start(input bit [7:0] mask, input int stk, input int wfix, input bit hng);
    @(negedge clk);
    arm(mask, stk, wfix, hng);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_at_trigger", busy, 1);
    chk("done_cleared", done, 0);
    chk("timeout_cleared", timeout, 0);
    chk("err_cleared", err_count, 0);
  endtask

  task automatic wait_done(input bit noise);
    int n = 0;
    while (rq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (noise && busy && !done && !start && $urandom_range(0, 5) == 0) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (rq.size() != 0) begin
      n_chk++;
      $display("FAIL run_complete: done not seen after %0d cycles, want within 3000", n);
      rq.delete();
    end
    chk("all_transfers_seen", tq.size(), 0);
    tq.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_psel"}, apb.psel, 0);
    chk({tag, "_penable"}, apb.penable, 0);
    chk({tag, "_pwrite"}, apb.pwrite, 0);
    chk({tag, "_paddr"}, apb.paddr, 0);
    chk({tag, "_pwdata"}, apb.pwdata, 0);
    chk({tag, "_pstrb"}, apb.pstrb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask

  // RAM slave + transfer monitor; responses set at negedge for the next edge
  int w_cur = 0, wc = 0, ks;
  logic [31:0] sa, sd;
  txn_t ts;
  initial begin
    apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;
    for (int j = 0; j < 4; j++) mem[j] = '0;
  end
  always @(negedge clk) begin
    if (apb.psel && !apb.penable) begin
      w_cur = (wq.size() != 0) ? wq.pop_front() : 0;
      wc = 0; sa = apb.paddr; sd = apb.pwdata;
      apb.pready = 1'b0;
    end else if (apb.psel && apb.penable) begin
      chk("addr_stable", apb.paddr, sa);
      chk("wdata_stable", apb.pwdata, sd);
      if (!hang && wc >= w_cur) begin
        ks = (apb.pwrite ? 0 : 4) + int'(apb.paddr[3:2]);
        if (tq.size() == 0) begin
          n_chk++;
          $display("FAIL extra_transfer: got addr 0x%0h, want no transfer", apb.paddr);
        end else begin
          ts = tq.pop_front();
          chk("paddr", apb.paddr, ts.addr);
          chk("pwrite", apb.pwrite, ts.wr);
          chk("pstrb", apb.pstrb, ts.wr ? 32'hF : 32'h0);
          if (ts.wr) chk("pwdata", apb.pwdata, ts.data);
        end
        apb.pslverr = slv_mask[ks];
        if (apb.pwrite) mem[apb.paddr[3:2]] = apb.pwdata;
        else apb.prdata = (int'(apb.paddr[3:2]) == stuck) ? 32'h0 : mem[apb.paddr[3:2]];
        apb.pready = 1'b1;
      end else begin
        apb.pready = 1'b0;
        wc++;
      end
    end else begin
      apb.pready = 1'b0;
      apb.pslverr = 1'b0;
    end
  end

  // result monitor: pops the expected run outcome whenever done rises
  logic done_p = 1'b0;
  res_t rm;
  always @(negedge clk) begin
    if (done && !done_p) begin
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL done_unexpected: got done=1, want no pending run");
      end else begin
        rm = rq.pop_front();
        chk("err_count", err_count, rm.err);
        chk("pass", pass, rm.pass);
        chk("timeout", timeout, rm.tmo);
        chk("done_cycle", cyc, rm.cyc);
        chk("busy_low_at_done", busy, 0);
      end
    end
    done_p <= done;
  end

  initial begin
    int n;
    #3 chk_zero("reset");
    repeat (2) @(negedge clk);
    arm(8'h00, -1, 0, 1'b0);
    rstn = 1'b1;
    wait_done(1'b0);

    go_start(8'h00, 2, 0, 1'b0);  wait_done(1'b0);
    go_start(8'h02, 2, 0, 1'b0);  wait_done(1'b0);
    go_start(8'h00, -1, 3, 1'b0); wait_done(1'b0);
    go_start(8'h40, 2, 0, 1'b0);  wait_done(1'b0);
    go_start(8'hFF, -1, 0, 1'b0); wait_done(1'b0);
    go_start(8'h00, -1, 0, 1'b0); wait_done(1'b1);
    for (int r = 0; r < 6; r++) begin
      go_start(8'($urandom), int'($urandom_range(0, 4)), -1, 1'b0);
      wait_done(1'b1);
    end

    go_start(8'h00, -1, 0, 1'b1);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    chk("psel_after_timeout", apb.psel, 0);
    chk("penable_after_timeout", apb.penable, 0);
    chk("timeout_held", timeout, 1);
    chk("done_held", done, 1);
    go_start(8'h00, -1, -1, 1'b0);
    wait_done(1'b0);

    go_start(8'h00, -1, 0, 1'b0);
    n = 0;
    while (!(apb.psel && !apb.penable && !apb.pwrite && apb.paddr == 32'h1008) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL read2_seen: got no read of 0x1008 in %0d cycles, want one", n);
    end
    #2 rstn = 1'b0;
    #1 chk_zero("midrun_reset");
    tq.delete(); rq.delete(); wq.delete();
    @(negedge clk);
    arm(8'h00, -1, 0, 1'b0);
    rstn = 1'b1;
    wait_done(1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
